synapse_frame_loader: RTL and testbench

//  Transmit-side loader for the 8-lane synapse adder tree. Accepts input bytes one per cycle

---
 rtl/neuron_pkg.sv | 12 +
 rtl/synapse_frame_loader_if.sv | 24 ++
 rtl/frame_hold_reg.sv | 40 ++++
 rtl/synapse_frame_loader.sv | 94 +++++++++
 tb/tb_synapse_frame_loader.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and sizing for the synapse adder-tree datapath.
// A frame is NEURON_LANES lanes of NEURON_WIDTH bits, with lane 0 in the least significant bits.
package neuron_pkg;

    localparam int unsigned NEURON_WIDTH = 8;
    localparam int unsigned NEURON_LANES = 8;
    localparam int unsigned CNT_W        = $clog2(NEURON_LANES);

    typedef logic [NEURON_WIDTH-1:0] lane_t;
    typedef lane_t [NEURON_LANES-1:0] frame_t;

endpackage

// File: rtl/synapse_frame_loader_if.sv
// Byte stream in and frame stream out of the synapse frame loader.
// The master drives the byte stream and out_ready; the slave is the loader itself.
interface synapse_frame_loader_if;

    neuron_pkg::lane_t  in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    neuron_pkg::frame_t out_lanes;
    logic               out_valid;
    logic               out_ready;
    logic               frame_short;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_lanes, out_valid, frame_short
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_lanes, out_valid, frame_short
    );

endinterface

// File: rtl/frame_hold_reg.sv
// Output hold stage: a registered frame with its valid and short flags.
// A load takes priority over a consume, so a frame can be consumed and replaced at the same edge.
module frame_hold_reg
    import neuron_pkg::*;
(
    input  logic   CK,
    input  logic   RB,
    input  logic   i_load,
    input  frame_t i_frame,
    input  logic   i_short,
    input  logic   i_ready,
    output frame_t o_frame,
    output logic   o_valid,
    output logic   o_short
);

    frame_t r_frame;
    logic   r_valid;
    logic   r_short;

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_frame <= '0;
            r_valid <= 1'b0;
            r_short <= 1'b0;
        end else if (i_load) begin
            r_frame <= i_frame;
            r_valid <= 1'b1;
            r_short <= i_short;
        end else if (r_valid && i_ready) begin
            // The frame data stays on the bus after it has been consumed.
            r_valid <= 1'b0;
        end
    end

    assign o_frame = r_frame;
    assign o_valid = r_valid;
    assign o_short = r_short;

endmodule

// File: rtl/synapse_frame_loader.sv
// Assembles a byte stream into 8-lane frames, lane 0 first, for the adder tree.
// The fill stage and the hold stage are double-buffered, so frames can stream at 1 byte per cycle.
module synapse_frame_loader
    import neuron_pkg::*;
(
    input  logic                   CK,
    input  logic                   RB,
    synapse_frame_loader_if.slave  bus
);

    logic [CNT_W-1:0] r_count;
    frame_t           r_fill;
    logic             r_fill_full;
    logic             r_fill_short;
    logic             r_en;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_lane;
    logic             w_complete;
    logic             w_short_in;
    logic             w_hold_valid;
    logic             w_hold_free;
    logic             w_load;
    frame_t           w_frame;
    frame_t           w_load_frame;
    logic             w_load_short;

    // r_en keeps in_ready low through reset and until the first edge after release.
    assign w_in_ready  = r_en && !r_fill_full;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last_lane = (r_count == CNT_W'(NEURON_LANES - 1));
    assign w_complete  = w_accept && (w_last_lane || bus.in_last);
    assign w_short_in  = bus.in_last && !w_last_lane;
    assign w_hold_free = !w_hold_valid || bus.out_ready;
    assign w_load      = w_hold_free && (r_fill_full || w_complete);

    // The fill lanes above r_count are always zero, which zero-pads short frames.
    always_comb begin
        w_frame          = r_fill;
        w_frame[r_count] = bus.in_data;
    end

    assign w_load_frame = r_fill_full ? r_fill : w_frame;
    assign w_load_short = r_fill_full ? r_fill_short : w_short_in;

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_count      <= '0;
            r_fill       <= '0;
            r_fill_full  <= 1'b0;
            r_fill_short <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (r_fill_full) begin
                if (w_hold_free) begin
                    r_count      <= '0;
                    r_fill       <= '0;
                    r_fill_full  <= 1'b0;
                    r_fill_short <= 1'b0;
                end
            end else if (w_accept) begin
                if (w_complete && w_hold_free) begin
                    r_count <= '0;
                    r_fill  <= '0;
                end else if (w_complete) begin
                    r_fill[r_count] <= bus.in_data;
                    r_fill_full     <= 1'b1;
                    r_fill_short    <= w_short_in;
                end else begin
                    r_fill[r_count] <= bus.in_data;
                    r_count         <= r_count + CNT_W'(1);
                end
            end
        end
    end

    frame_hold_reg u_hold (
        .CK      (CK),
        .RB      (RB),
        .i_load  (w_load),
        .i_frame (w_load_frame),
        .i_short (w_load_short),
        .i_ready (bus.out_ready),
        .o_frame (bus.out_lanes),
        .o_valid (w_hold_valid),
        .o_short (bus.frame_short)
    );

    assign bus.out_valid = w_hold_valid;
    assign bus.in_ready  = w_in_ready;

endmodule

// File: tb/tb_synapse_frame_loader.sv
// Directed and randomized bench for synapse_frame_loader.
// A queue model holds the finished frames that have not been consumed yet.
module tb_synapse_frame_loader;
    import neuron_pkg::*;

    logic CK = 1'b0;
    logic RB = 1'b1;
    always #5 CK = ~CK;

    synapse_frame_loader_if bus ();

    synapse_frame_loader dut (
        .CK  (CK),
        .RB  (RB),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        frame_t lanes;
        logic   sh;
    } exp_t;

    // Frames finished but not consumed; entry 0 is what the output should show.
    exp_t   m_q[$];
    lane_t  m_fill[$];
    frame_t m_last;
    logic   m_short_last;
    logic   m_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs();
        logic   v;
        frame_t lanes;
        logic   sh;
        v     = (m_q.size() > 0);
        lanes = v ? m_q[0].lanes : m_last;
        sh    = v ? m_q[0].sh : m_short_last;
        chk("out_valid", 64'(bus.out_valid), 64'(v));
        chk("out_lanes", 64'(bus.out_lanes), 64'(lanes));
        chk("frame_short", 64'(bus.frame_short), 64'(sh));
        chk("in_ready", 64'(bus.in_ready), 64'(m_en && (m_q.size() < 2)));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check the outputs.
    task automatic step(input logic v, input lane_t d, input logic l, input logic r);
        logic acc;
        logic cons;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        acc  = v && m_en && (m_q.size() < 2);
        cons = (m_q.size() > 0) && r;
        @(posedge CK);
        if (cons) begin
            m_last       = m_q[0].lanes;
            m_short_last = m_q[0].sh;
            void'(m_q.pop_front());
        end
        if (acc) begin
            m_fill.push_back(d);
            if (l || (m_fill.size() == NEURON_LANES)) begin
                exp_t e;
                e.lanes = '0;
                for (int i = 0; i < m_fill.size(); i++) e.lanes[i] = m_fill[i];
                e.sh = (m_fill.size() < NEURON_LANES);
                m_q.push_back(e);
                m_fill.delete();
            end
        end
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        RB            = 1'b0;
        m_q.delete();
        m_fill.delete();
        m_last       = '0;
        m_short_last = 1'b0;
        m_en         = 1'b0;
        #1;
        check_outs();
        repeat (2) @(posedge CK);
        @(negedge CK);
        RB = 1'b1;
        @(posedge CK);
        m_en = 1'b1;
        #1;
        check_outs();
    endtask

    initial begin
        #2;
        do_reset();

        // Single full frame
        for (int i = 1; i <= 8; i++) step(1'b1, lane_t'(i), 1'b0, 1'b1);
        chk("t1_lanes", 64'(bus.out_lanes), 64'h0807060504030201);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back frames
        for (int i = 0; i < 16; i++) begin
            step(1'b1, lane_t'(i), 1'b0, 1'b1);
            if (i == 7) chk("t2_frame0", 64'(bus.out_lanes), 64'h0706050403020100);
        end
        chk("t2_frame1", 64'(bus.out_lanes), 64'h0F0E0D0C0B0A0908);
        step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: hold and fill both occupied
        for (int i = 0; i < 16; i++) step(1'b1, lane_t'(8'h40 + i), 1'b0, 1'b0);
        chk("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t3_frame1", 64'(bus.out_lanes), 64'h4F4E4D4C4B4A4948);
        chk("t3_in_ready_high", 64'(bus.in_ready), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Short frame, then a normal one
        step(1'b1, 8'hA1, 1'b0, 1'b1);
        step(1'b1, 8'hA2, 1'b0, 1'b1);
        step(1'b1, 8'hA3, 1'b1, 1'b1);
        chk("t4_lanes", 64'(bus.out_lanes), 64'h0000000000A3A2A1);
        chk("t4_short", 64'(bus.frame_short), 64'd1);
        for (int i = 0; i < 7; i++) step(1'b1, lane_t'(8'hB0 + i), 1'b0, 1'b1);
        step(1'b1, 8'hB7, 1'b1, 1'b1);
        chk("t4_full_short", 64'(bus.frame_short), 64'd0);

        // Single-lane frame
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("t5_lanes", 64'(bus.out_lanes), 64'h00000000000000FF);
        chk("t5_valid", 64'(bus.out_valid), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset with a held frame and a partial fill
        for (int i = 0; i < 13; i++) step(1'b1, lane_t'(8'h60 + i), 1'b0, 1'b0);
        do_reset();
        chk("t6_lanes_cleared", 64'(bus.out_lanes), 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, lane_t'(8'h30 + i), 1'b0, 1'b1);
        chk("t6_clean_frame", 64'(bus.out_lanes), 64'h3736353433323130);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_one_frame", 64'(bus.out_valid), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 3) != 0, lane_t'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
